// File: rtl/decode_stage.sv
// RV32I/RV64I decode pipeline stage: combinational decode on the input side,
// registered bundle behind a main + skid buffer with valid/ready on both sides.
//
// state | meaning
// EMPTY | no bundle held, in_ready=1, out_valid=0
// MAIN  | one bundle in main, skid empty
// FULL  | main and skid both occupied, in_ready=0
module decode_stage #(
  parameter int DATAW  = 32,
  parameter int ADDRW  = 5,
  parameter int N_BITS = $clog2(DATAW),
  parameter int PCW    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PCW-1:0]    in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PCW-1:0]    out_pc,
  output logic [31:0]       out_instr,
  output logic [6:0]        opcode,
  output logic [ADDRW-1:0]  addr_rd,
  output logic [ADDRW-1:0]  addr_rs1,
  output logic [ADDRW-1:0]  addr_rs2,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [DATAW-1:0]  imm,
  output logic [N_BITS-1:0] shamt,
  output logic [5:0]        fmt,
  output logic              rd_we,
  output logic              rs1_used,
  output logic              rs2_used,
  output logic              is_ecall,
  output logic              is_ebreak,
  output logic              illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [5:0] FMT_R = 6'b000001;
  localparam logic [5:0] FMT_I = 6'b000010;
  localparam logic [5:0] FMT_S = 6'b000100;
  localparam logic [5:0] FMT_B = 6'b001000;
  localparam logic [5:0] FMT_U = 6'b010000;
  localparam logic [5:0] FMT_J = 6'b100000;

  // Bits above the shamt field, right-aligned; only instr[30] may be set (SRAI).
  localparam logic [11:0] SRAI_PAT = 12'h400 >> N_BITS;
  localparam logic [2:0]  ST_MAX   = (DATAW == 64) ? 3'd3 : 3'd2;

  typedef struct packed {
    logic [PCW-1:0]   pc;
    logic [31:0]      instr;
    logic [DATAW-1:0] imm;
    logic [5:0]       fmt;
    logic             rd_we;
    logic             rs1_used;
    logic             rs2_used;
    logic             is_ecall;
    logic             is_ebreak;
    logic             illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    MAIN  = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e  state_q, state_d;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  bundle_t dec;

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] shift_hi;
  logic        bad;
  logic        sys;
  logic        in_fire;
  logic        out_fire;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.instr = in_instr;
    bad       = 1'b0;
    sys       = 1'b0;
    shift_hi  = in_instr[31:20] >> N_BITS;
    case (op)
      OP_R: begin
        dec.fmt = FMT_R;
        bad = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      OP_IMM: begin
        dec.fmt = FMT_I;
        if ((f3 == 3'd1) || (f3 == 3'd5)) begin
          dec.imm = DATAW'(in_instr[20 +: N_BITS]);
          bad = !((shift_hi == 12'd0) || ((f3 == 3'd5) && (shift_hi == SRAI_PAT)));
        end else begin
          dec.imm = DATAW'($signed(in_instr[31:20]));
        end
      end
      OP_LOAD: begin
        dec.fmt = FMT_I;
        dec.imm = DATAW'($signed(in_instr[31:20]));
        bad = (DATAW == 64) ? (f3 == 3'd7) : ((f3 == 3'd3) || (f3 >= 3'd6));
      end
      OP_JALR: begin
        dec.fmt = FMT_I;
        dec.imm = DATAW'($signed(in_instr[31:20]));
        bad = (f3 != 3'd0);
      end
      OP_SYSTEM: begin
        sys = 1'b1;
        dec.fmt = FMT_I;
        dec.imm = DATAW'($signed(in_instr[31:20]));
        dec.is_ecall  = (in_instr == 32'h0000_0073);
        dec.is_ebreak = (in_instr == 32'h0010_0073);
        bad = !(dec.is_ecall || dec.is_ebreak);
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = DATAW'($signed({in_instr[31:25], in_instr[11:7]}));
        bad = (f3 > ST_MAX);
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        dec.imm = DATAW'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));
        bad = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        dec.imm = DATAW'($signed({in_instr[31:12], 12'b0}));
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = DATAW'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0}));
      end
      OP_FENCE: ;
      default: bad = 1'b1;
    endcase
    dec.rd_we    = ((dec.fmt & (FMT_R | FMT_I | FMT_U | FMT_J)) != 6'd0) && !sys &&
                   (in_instr[11:7] != 5'd0);
    dec.rs1_used = ((dec.fmt & (FMT_R | FMT_I | FMT_S | FMT_B)) != 6'd0) && !sys;
    dec.rs2_used = ((dec.fmt & (FMT_R | FMT_S | FMT_B)) != 6'd0);
    if (bad) begin
      dec.imm       = '0;
      dec.fmt       = '0;
      dec.rd_we     = 1'b0;
      dec.rs1_used  = 1'b0;
      dec.rs2_used  = 1'b0;
      dec.is_ecall  = 1'b0;
      dec.is_ebreak = 1'b0;
    end
    dec.illegal = bad;
  end

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = dec;
            state_d = MAIN;
          end
        end
        MAIN: begin
          if (in_fire && out_fire) begin
            main_d = dec;
          end else if (in_fire) begin
            skid_d  = dec;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = MAIN;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign out_pc    = main_q.pc;
  assign out_instr = main_q.instr;
  assign opcode    = main_q.instr[6:0];
  assign addr_rd   = main_q.instr[7 +: ADDRW];
  assign addr_rs1  = main_q.instr[15 +: ADDRW];
  assign addr_rs2  = main_q.instr[20 +: ADDRW];
  assign funct3    = main_q.instr[14:12];
  assign funct7    = main_q.instr[31:25];
  assign shamt     = main_q.instr[20 +: N_BITS];
  assign imm       = main_q.imm;
  assign fmt       = main_q.fmt;
  assign rd_we     = main_q.rd_we;
  assign rs1_used  = main_q.rs1_used;
  assign rs2_used  = main_q.rs2_used;
  assign is_ecall  = main_q.is_ecall;
  assign is_ebreak = main_q.is_ebreak;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference decoder fills an expected queue
// on every accepted instruction; a negedge monitor checks occupancy and bundles.
module tb_decode_stage;
  localparam int DATAW  = 32;
  localparam int ADDRW  = 5;
  localparam int N_BITS = $clog2(DATAW);
  localparam int PCW    = 32;
  localparam logic [63:0] DMASK = (DATAW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]       in_instr, out_instr;
  logic [PCW-1:0]    in_pc, out_pc;
  logic [6:0]        opcode, funct7;
  logic [ADDRW-1:0]  addr_rd, addr_rs1, addr_rs2;
  logic [2:0]        funct3;
  logic [DATAW-1:0]  imm;
  logic [N_BITS-1:0] shamt;
  logic [5:0]        fmt;
  logic              rd_we, rs1_used, rs2_used, is_ecall, is_ebreak, illegal;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]    instr;
    logic [PCW-1:0] pc;
    logic [63:0]    imm;
    logic [5:0]     fmt;
    bit             rd_we, rs1, rs2, ec, eb, ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    bit          imm_chk;
    logic [5:0]  fmt;
    bit          ill, rd_we, rs1, rs2, ec, eb;
  } dir_t;

  exp_t sb[$];
  dir_t dir[10];

  decode_stage #(.DATAW(DATAW), .ADDRW(ADDRW), .N_BITS(N_BITS), .PCW(PCW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .opcode(opcode), .addr_rd(addr_rd), .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .shamt(shamt), .fmt(fmt),
    .rd_we(rd_we), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .is_ecall(is_ecall), .is_ebreak(is_ebreak), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input longint v, input int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  // Reference decoder written straight from the ISA rules.
  function automatic exp_t model(input logic [31:0] ins, input logic [PCW-1:0] pc);
    exp_t   e;
    int     op, f3, f7, rd, others;
    longint v;
    op = int'(ins[6:0]);
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    rd = int'(ins[11:7]);
    e.instr = ins; e.pc = pc; e.fmt = 6'd0;
    e.rd_we = 0; e.rs1 = 0; e.rs2 = 0; e.ec = 0; e.eb = 0; e.ill = 0;
    v = 0;
    case (op)
      'h33: begin
        e.fmt = 6'd1;
        e.ill = !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
      end
      'h13: begin
        e.fmt = 6'd2;
        if (f3 == 1 || f3 == 5) begin
          v = longint'(ins >> 20) % (longint'(1) << N_BITS);
          others = int'(ins >> (20 + N_BITS)) & ~(1 << (10 - N_BITS));
          e.ill = (others != 0) || (ins[30] && f3 != 5);
        end else begin
          v = sx(longint'(ins >> 20), 12);
        end
      end
      'h03: begin
        e.fmt = 6'd2; v = sx(longint'(ins >> 20), 12);
        e.ill = (DATAW == 32) ? (f3 == 3 || f3 >= 6) : (f3 == 7);
      end
      'h67: begin
        e.fmt = 6'd2; v = sx(longint'(ins >> 20), 12); e.ill = (f3 != 0);
      end
      'h73: begin
        e.fmt = 6'd2; v = sx(longint'(ins >> 20), 12);
        e.ec = (ins == 32'h73); e.eb = (ins == 32'h0010_0073);
        e.ill = !(e.ec || e.eb);
      end
      'h23: begin
        e.fmt = 6'd4; v = sx(longint'(f7) * 32 + longint'(rd), 12);
        e.ill = f3 > ((DATAW == 32) ? 2 : 3);
      end
      'h63: begin
        e.fmt = 6'd8;
        v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
               longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
        e.ill = (f3 == 2 || f3 == 3);
      end
      'h37, 'h17: begin
        e.fmt = 6'd16; v = sx(longint'(ins[31:12]) * 4096, 32);
      end
      'h6F: begin
        e.fmt = 6'd32;
        v = sx(longint'(ins[31]) * (longint'(1) << 20) + longint'(ins[19:12]) * 4096 +
               longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      end
      'h0F: ;
      default: e.ill = 1;
    endcase
    e.imm = 64'(v) & DMASK;
    if (e.ill) begin
      e.fmt = 6'd0; e.ec = 0; e.eb = 0;
    end else begin
      e.rd_we = (rd != 0) && (op == 'h33 || op == 'h13 || op == 'h03 || op == 'h67 ||
                              op == 'h37 || op == 'h17 || op == 'h6F);
      e.rs1 = (op == 'h33 || op == 'h13 || op == 'h03 || op == 'h67 || op == 'h23 || op == 'h63);
      e.rs2 = (op == 'h33 || op == 'h23 || op == 'h63);
    end
    return e;
  endfunction

  task automatic cmp_bundle(input exp_t e);
    chk("out_instr", 64'(out_instr), 64'(e.instr));
    chk("out_pc", 64'(out_pc), 64'(e.pc));
    chk("opcode", 64'(opcode), 64'(e.instr[6:0]));
    chk("addr_rd", 64'(addr_rd), 64'(e.instr[11:7]));
    chk("addr_rs1", 64'(addr_rs1), 64'(e.instr[19:15]));
    chk("addr_rs2", 64'(addr_rs2), 64'(e.instr[24:20]));
    chk("funct3", 64'(funct3), 64'(e.instr[14:12]));
    chk("funct7", 64'(funct7), 64'(e.instr[31:25]));
    chk("shamt", 64'(shamt), 64'(e.instr >> 20) & ((64'd1 << N_BITS) - 64'd1));
    chk("fmt", 64'(fmt), 64'(e.fmt));
    chk("rd_we", 64'(rd_we), 64'(e.rd_we));
    chk("rs1_used", 64'(rs1_used), 64'(e.rs1));
    chk("rs2_used", 64'(rs2_used), 64'(e.rs2));
    chk("is_ecall", 64'(is_ecall), 64'(e.ec));
    chk("is_ebreak", 64'(is_ebreak), 64'(e.eb));
    chk("illegal", 64'(illegal), 64'(e.ill));
    if (!e.ill) chk("imm", 64'(imm), e.imm);
  endtask

  // Monitor: queue depth is the expected occupancy; the head is the expected bundle.
  always @(negedge clk) begin
    if (!reset) begin
      chk("occ_out_valid", 64'(out_valid), 64'(sb.size() != 0));
      chk("occ_in_ready", 64'(in_ready), 64'(sb.size() < 2));
      if (out_valid && sb.size() > 0) cmp_bundle(sb[0]);
    end
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (in_valid && in_ready) sb.push_back(model(in_instr, in_pc));
    end
  end

  // Call at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [PCW-1:0] pc);
    int n;
    n = 0;
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int sel;
    r = $urandom();
    case ($urandom_range(0, 15))
      0: r[6:0] = 7'h33;
      1: r[6:0] = 7'h13;
      2: r[6:0] = 7'h03;
      3: r[6:0] = 7'h67;
      4: r[6:0] = 7'h23;
      5: r[6:0] = 7'h63;
      6: r[6:0] = 7'h37;
      7: r[6:0] = 7'h17;
      8: r[6:0] = 7'h6F;
      9: r[6:0] = 7'h0F;
      10: begin
        r[6:0] = 7'h33;
        r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      11: r = 32'h0000_0073;
      12: r = 32'h0010_0073;
      13: r[6:0] = 7'h73;
      14: begin
        r[6:0] = 7'h13;
        r[13:12] = 2'b01;
        r[14] = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 2);
        r[31:25] = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : 7'($urandom());
      end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dir[0] = '{32'hFFF00093, 64'hFFFF_FFFF, 1'b1, 6'b000010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    dir[1] = '{32'h123452B7, 64'h1234_5000, 1'b1, 6'b010000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    dir[2] = '{32'hFE000EE3, 64'hFFFF_FFFC, 1'b1, 6'b001000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    dir[3] = '{32'h00309093, 64'h3,         1'b1, 6'b000010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    dir[4] = '{32'h02309093, 64'h0,         1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    dir[5] = '{32'h00000073, 64'h0,         1'b1, 6'b000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    dir[6] = '{32'h00100073, 64'h1,         1'b1, 6'b000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    dir[7] = '{32'h30200073, 64'h0,         1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    dir[8] = '{32'h00000000, 64'h0,         1'b0, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    dir[9] = '{32'h0FF0000F, 64'h0,         1'b1, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_imm", 64'(imm), 64'd0);

    // Directed decode cases, one at a time through an empty stage.
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      send(dir[i].instr, PCW'(32'h1000 + i * 4));
      @(negedge clk);
      chk("dir_out_valid", 64'(out_valid), 64'd1);
      chk("dir_fmt", 64'(fmt), 64'(dir[i].fmt));
      chk("dir_illegal", 64'(illegal), 64'(dir[i].ill));
      chk("dir_rd_we", 64'(rd_we), 64'(dir[i].rd_we));
      chk("dir_rs1_used", 64'(rs1_used), 64'(dir[i].rs1));
      chk("dir_rs2_used", 64'(rs2_used), 64'(dir[i].rs2));
      chk("dir_ecall", 64'(is_ecall), 64'(dir[i].ec));
      chk("dir_ebreak", 64'(is_ebreak), 64'(dir[i].eb));
      if (dir[i].imm_chk) chk("dir_imm", 64'(imm), dir[i].imm);
      @(posedge clk); #1;
    end

    // Backpressure: two accepted, third held until the stage drains.
    out_ready = 1'b0;
    send(32'h00100093, 32'h2000);
    send(32'h00200113, 32'h2004);
    in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 32'h2008;
    @(negedge clk);
    chk("bp_in_ready_full", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_seq0_valid", 64'(out_valid), 64'd1);
    chk("bp_seq0_instr", 64'(out_instr), 64'h00100093);
    @(negedge clk);
    chk("bp_seq1_valid", 64'(out_valid), 64'd1);
    chk("bp_seq1_instr", 64'(out_instr), 64'h00200113);
    chk("bp_seq1_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_seq2_valid", 64'(out_valid), 64'd1);
    chk("bp_seq2_instr", 64'(out_instr), 64'h00300193);

    // Flush while FULL with an instruction offered.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h00400213, 32'h3000);
    send(32'h00500293, 32'h3004);
    in_valid = 1'b1; in_instr = 32'h00600313; in_pc = 32'h3008; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_full_out_valid", 64'(out_valid), 64'd0);
    chk("flush_full_in_ready", 64'(in_ready), 64'd1);

    // Flush in MAIN while a would-be in_fire is present.
    @(posedge clk); #1;
    send(32'h00700393, 32'h4000);
    in_valid = 1'b1; in_instr = 32'h00800413; in_pc = 32'h4004; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_main_out_valid", 64'(out_valid), 64'd0);
    chk("flush_main_in_ready", 64'(in_ready), 64'd1);

    // Reset in MAIN.
    @(posedge clk); #1;
    send(32'h00900493, 32'h5000);
    in_valid = 1'b1; in_instr = 32'h00A00513; in_pc = 32'h5004; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_main_out_valid", 64'(out_valid), 64'd0);
    chk("rst_main_in_ready", 64'(in_ready), 64'd1);
    chk("rst_main_out_pc", 64'(out_pc), 64'd0);

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) < 2);
      reset     = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = rand_instr();
      in_pc     = PCW'($urandom());
    end
    @(posedge clk); #1;
    flush = 1'b0; reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered RV32I/RV64I instruction-decode pipeline stage with a valid/ready handshake on both sides and a 2-entry (main + skid) output buffer. It sits between fetch and register-read/execute and decodes combinationally on the input side. The decoded bundle is registered, so every output comes straight from a flop. Beyond plain field extraction it adds DATAW-generic immediates and shamt, illegal-instruction detection, ecall/ebreak flags, register-use/write-enable hints, PC passthrough and a pipeline flush.

Parameters:
DATAW, 32, datapath/XLEN width; legal values 32 or 64 (instruction width is always 32).
ADDRW, 5, register address width; must be 5.
N_BITS, $clog2(DATAW), shamt width (5 for RV32, 6 for RV64).
PCW, 32, program-counter width.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
flush  input  1  discard all buffered instructions.
in_valid  input  1  instruction and PC presented.
in_ready  output  1  stage can accept; equals !skid_valid (registered).
in_instr  input  32  raw instruction.
in_pc  input  PCW  instruction address.
out_valid  output  1  decoded bundle valid.
out_ready  input  1  downstream accepts the bundle.
out_pc  output  PCW  PC of the bundle.
out_instr  output  32  raw instruction.
opcode  output  7  instr[6:0].
addr_rd  output  ADDRW  instr[11:7].
addr_rs1  output  ADDRW  instr[19:15].
addr_rs2  output  ADDRW  instr[24:20].
funct3  output  3  instr[14:12].
funct7  output  7  instr[31:25].
imm  output  DATAW  extended immediate.
shamt  output  N_BITS  instr[20+N_BITS-1:20].
fmt  output  6  one-hot {J,U,B,S,I,R}; all-zero for FENCE and illegal.
rd_we  output  1  instruction writes rd and rd != 0.
rs1_used  output  1  reads rs1 (R, I except ecall/ebreak, S, B).
rs2_used  output  1  reads rs2 (R, S, B).
is_ecall  output  1  0x00000073.
is_ebreak  output  1  0x00100073.
illegal  output  1  illegal or unsupported encoding.

Behaviour:
- Fire definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Reset: state EMPTY; out_valid=0, skid_valid=0, in_ready=1 on the first cycle after reset; all bundle registers 0. Inputs sampled while reset is high are ignored. A reset mid-operation drops all buffered entries.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Sustained throughput is 1 per cycle when out_ready=1.
- State machine (state = {skid_valid, out_valid}):
  - EMPTY: in_fire -> MAIN.
  - MAIN: in_fire & out_fire -> MAIN (main reloaded); in_fire & !out_fire -> FULL (skid captures); out_fire only -> EMPTY.
  - FULL: in_ready=0; out_fire -> MAIN (skid moves to main, skid cleared).
- Ordering: FIFO order is always preserved; no drop, no duplicate.
- Flush: has priority over every transition. The next state is EMPTY, and any in_fire in the flush cycle is discarded. The flush takes effect on the next edge.
- Output stability: bundle outputs hold while out_valid & !out_ready.
- Decoded classes: R 0110011, I = {0010011, 0000011, 1100111, 1110011 ecall/ebreak}, S 0100011, B 1100011, U = {0110111, 0010111}, J 1101111, FENCE 0001111 (legal no-op, rd_we=0).
- Immediate rules (sign extension is to DATAW in every case):
  - R: 0.
  - I-shift (0010011, funct3 1 or 5): zero-extended shamt.
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: sext({instr[31:12], 12'b0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - Otherwise: 0.
- illegal=1 (and fmt=0, rd_we=0, rs*_used=0) when any of the following holds:
  - instr[1:0] != 11, or the opcode is not listed above.
  - R with funct7 not 0x00/0x20, or funct7=0x20 with funct3 not 0/5.
  - I-shift with instr[31:20+N_BITS] not zero, except bit30 set for SRAI.
  - Load with funct3 in {3,6,7} for DATAW=32, or funct3=7 for DATAW=64.
  - Store with funct3 > 2 for DATAW=32, or > 3 for DATAW=64.
  - Branch with funct3 in {2,3}.
  - JALR with funct3 != 0.
  - 1110011 other than ecall/ebreak (CSR/xRET are unsupported).
- The RV64 W-opcodes are out of scope and therefore illegal.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), empty stage -> next cycle out_valid=1, rd=1, imm=0xFFFFFFFF, fmt=I, rd_we=1, rs1_used=1, rs2_used=0.
- LUI x5,0x12345 (0x123452B7) -> imm=0x12345000, fmt=U. BEQ x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, fmt=B, rd_we=0, rs2_used=1.
- DATAW=32: SLLI x1,x1,3 (0x00309093) -> shamt=3, imm=3, legal. 0x02309093 -> illegal=1, fmt=0. DATAW=64: 0x02309093 -> legal, shamt=35.
- 0x00000073 -> is_ecall=1, rd_we=0. 0x00100073 -> is_ebreak=1. 0x30200073 and 0x00000000 -> illegal=1.
- Backpressure: out_ready=0 while 3 instrs are offered back-to-back -> two accepted, in_ready=0 from the cycle after the 2nd. Then out_ready=1 -> the 3 instrs emerge in order, no gaps after the first, and the held outputs stay stable.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flush-cycle instr is never output. Reset asserted in MAIN -> same result.
